// File: rtl/riscv_fetch.sv
// riscv_fetch: RV32I instruction-fetch stage.
// The stage generates the PC and keeps at most one instruction-memory request
// outstanding. A one-entry skid buffer absorbs a response that lands while
// decode is stalled. The stage drives the IF/ID pipeline register.
// Optional feature: define RISCV_FETCH_ALIGN_CHECK_EN to flag misaligned
// redirect targets on o_fetch_misalign. With the macro undefined, the low two
// target bits are forced to zero instead.

module riscv_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_fetch_stall,
    input  logic        i_fetch_redirect,
    input  logic [31:0] i_fetch_redirect_pc,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc_4
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    ,
    output logic        o_fetch_misalign
`endif
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        outstanding_q, outstanding_d;
    logic        kill_q, kill_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc_4_q, if_id_pc_4_d;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    logic        misalign_q, misalign_d;
`endif

    logic        imem_req;
    logic        grant;
    logic        resp_live;
    logic        fetch_block;
    logic [31:0] redirect_target;

    // Request gating, grant detection and acceptance of live responses.
    always_comb begin
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
        fetch_block     = misalign_q;
        redirect_target = i_fetch_redirect_pc;
`else
        fetch_block     = 1'b0;
        redirect_target = i_fetch_redirect_pc & ~32'h0000_0003;
`endif
        // Do not issue while the skid buffer is full. Do not issue while a
        // stalled decode could leave the in-flight response with nowhere to go.
        imem_req  = (state_q == ST_RUN) && !skid_valid_q
                    && !(i_fetch_stall && outstanding_q) && !fetch_block;
        grant     = imem_req && i_imem_gnt;
        // Drop a response that has no matching grant, that was killed by an
        // earlier redirect, or that lands in a redirect cycle.
        resp_live = i_imem_rvalid && outstanding_q && !kill_q && !i_fetch_redirect;
    end

    // Next-state logic for the PC, the request tracking, the skid buffer and IF/ID.
    always_comb begin
        // NOTE: every *_d is given its hold value first, so no path through this block can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = grant;
        kill_d        = i_fetch_redirect && grant;
        req_pc_d      = grant ? pc_q : req_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc_4_d  = if_id_pc_4_q;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
        misalign_d    = misalign_q;
`endif

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (i_fetch_redirect) begin
            // A redirect flushes everything and restarts at the target. It
            // takes priority over a stall.
            pc_d          = redirect_target;
            skid_valid_d  = 1'b0;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
            misalign_d    = |i_fetch_redirect_pc[1:0];
`endif
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (!i_fetch_stall) begin
                if (skid_valid_q) begin
                    if_id_valid_d = 1'b1;
                    if_id_instr_d = skid_instr_q;
                    if_id_pc_d    = skid_pc_q;
                    if_id_pc_4_d  = skid_pc_q + 32'd4;
                    // A response landing while the skid drains takes its place.
                    skid_valid_d  = resp_live;
                    if (resp_live) begin
                        skid_instr_d = i_imem_rdata;
                        skid_pc_d    = req_pc_q;
                    end
                end else if (resp_live) begin
                    if_id_valid_d = 1'b1;
                    if_id_instr_d = i_imem_rdata;
                    if_id_pc_d    = req_pc_q;
                    if_id_pc_4_d  = req_pc_q + 32'd4;
                end else begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                end
            end else if (resp_live) begin
                skid_valid_d = 1'b1;
                skid_instr_d = i_imem_rdata;
                skid_pc_d    = req_pc_q;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            req_pc_q      <= RESET_PC;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= RESET_PC;
            if_id_pc_4_q  <= RESET_PC + 32'd4;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            req_pc_q      <= req_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc_4_q  <= if_id_pc_4_d;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    assign o_imem_req    = imem_req;
    assign o_imem_addr   = pc_q;
    assign o_if_id_valid = if_id_valid_q;
    assign o_if_id_instr = if_id_instr_q;
    assign o_if_id_pc    = if_id_pc_q;
    assign o_if_id_pc_4  = if_id_pc_4_q;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    assign o_fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Testbench for riscv_fetch. Directed scenarios plus a randomized run checked
// against a program-order model: fetch addresses and delivered instructions
// must follow RESET_PC, +4, ... and restart at every redirect target.

module tb_riscv_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    // Second instance exercising PC wrap-around
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    logic        w_misalign;
`endif

    riscv_fetch dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .i_fetch_stall(stall), .i_fetch_redirect(redirect),
        .i_fetch_redirect_pc(redirect_pc),
        .o_if_id_valid(valid), .o_if_id_instr(instr),
        .o_if_id_pc(pc), .o_if_id_pc_4(pc4)
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
        , .o_fetch_misalign(misalign)
`endif
    );

    riscv_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_gnt(1'b1),
        .i_imem_rvalid(w_rvalid), .i_imem_rdata(w_rdata),
        .i_fetch_stall(1'b0), .i_fetch_redirect(1'b0),
        .i_fetch_redirect_pc(32'h0),
        .o_if_id_valid(w_valid), .o_if_id_instr(w_instr),
        .o_if_id_pc(w_pc), .o_if_id_pc_4(w_pc4)
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
        , .o_fetch_misalign(w_misalign)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int delivered = 0;
    bit model_en = 1'b0;

    // Reference-model state: program order of fetches and deliveries
    logic [31:0] exp_fetch, exp_deliver;
    bit          prev_grant, prev_hold, prev_redirect;
    logic        p_valid;
    logic [31:0] p_instr, p_pc, p_pc4;

    // Instruction memory contents: a fixed function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Reference model, evaluated once per cycle at the negative edge
    task automatic model_step();
        bit g;
        g = req && gnt;
        if (stall && prev_grant) begin
            n_vec++;
            if (req !== 1'b0) begin n_err++; $display("FAIL rnd_req_gate: req=%0b want 0", req); end
        end
        if (g) begin
            n_vec++;
            if (addr !== exp_fetch) begin n_err++; $display("FAIL rnd_fetch_addr: got %h want %h", addr, exp_fetch); end
            exp_fetch = exp_fetch + 32'd4;
        end
        if (prev_redirect) begin
            n_vec++;
            if (valid !== 1'b0 || instr !== NOP) begin
                n_err++; $display("FAIL rnd_flush: valid=%0b instr=%h want 0/%h", valid, instr, NOP);
            end
        end else if (prev_hold) begin
            n_vec++;
            if ({valid, instr, pc, pc4} !== {p_valid, p_instr, p_pc, p_pc4}) begin
                n_err++; $display("FAIL rnd_hold: got %0b/%h/%h/%h want %0b/%h/%h/%h",
                                  valid, instr, pc, pc4, p_valid, p_instr, p_pc, p_pc4);
            end
        end
        if (valid === 1'b1 && !stall && !redirect) begin
            n_vec++;
            if (pc !== exp_deliver || instr !== mem_word(exp_deliver) || pc4 !== exp_deliver + 32'd4) begin
                n_err++; $display("FAIL rnd_deliver: got pc=%h instr=%h pc4=%h want pc=%h instr=%h",
                                  pc, instr, pc4, exp_deliver, mem_word(exp_deliver));
            end
            exp_deliver = exp_deliver + 32'd4;
            delivered++;
        end
        if (redirect) begin
            exp_fetch   = redirect_pc;
            exp_deliver = redirect_pc;
        end
        prev_grant    = g;
        prev_hold     = stall && !redirect;
        prev_redirect = redirect;
        p_valid = valid; p_instr = instr; p_pc = pc; p_pc4 = pc4;
    endtask

    // Finish the current cycle: sample at negedge, then model the one-cycle memory response
    task automatic tick();
        bit g, wg;
        logic [31:0] a, wa;
        @(negedge clk);
        g = req && gnt; a = addr; wg = w_req; wa = w_addr;
        if (model_en) model_step();
        @(posedge clk);
        #1;
        rvalid = g;  rdata = mem_word(a);
        w_rvalid = wg; w_rdata = mem_word(wa);
    endtask

    // Reset, release, then advance n cycles; cycle 0 after release is BOOT
    task automatic reset_and_run(input int n);
        rst = 1'b1; gnt = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        rst = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; gnt = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        rvalid = 1'b0; rdata = 32'h0; w_rvalid = 1'b0; w_rdata = 32'h0;
        tick(); tick(); #1;
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", req); end
        n_vec++; if (addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", addr); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_vec++; if (instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_vec++; if (pc4 !== 32'h4) begin n_err++; $display("FAIL reset_pc4: got %h want 4", pc4); end
        n_vec++; if (w_pc4 !== 32'h0) begin n_err++; $display("FAIL reset_wrap_pc4: got %h want 0", w_pc4); end
        rst = 1'b0; #1;
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL boot_req: got %0b want 0", req); end
        tick(); #1;
        n_vec++; if (req !== 1'b1 || addr !== 32'h0) begin n_err++; $display("FAIL boot_fetch0: req=%0b addr=%h want 1/0", req, addr); end
        tick(); #1;
        n_vec++; if (addr !== 32'h4 || valid !== 1'b0) begin n_err++; $display("FAIL fetch1: addr=%h valid=%0b want 4/0", addr, valid); end
        tick(); #1;
        n_vec++; if (addr !== 32'h8 || valid !== 1'b1 || pc !== 32'h0 || pc4 !== 32'h4 || instr !== mem_word(32'h0)) begin
            n_err++; $display("FAIL ifid0: addr=%h valid=%0b pc=%h pc4=%h instr=%h", addr, valid, pc, pc4, instr);
        end
        tick(); #1;
        n_vec++; if (valid !== 1'b1 || pc !== 32'h4 || pc4 !== 32'h8) begin n_err++; $display("FAIL ifid1: valid=%0b pc=%h pc4=%h want 1/4/8", valid, pc, pc4); end
        tick(); #1;
        n_vec++; if (valid !== 1'b1 || pc !== 32'h8 || pc4 !== 32'hC) begin n_err++; $display("FAIL ifid2: valid=%0b pc=%h pc4=%h want 1/8/c", valid, pc, pc4); end
    endtask

    task automatic test_stall();
        reset_and_run(4);
        stall = 1'b1; #1;
        n_vec++; if (req !== 1'b0 || valid !== 1'b1 || pc !== 32'h4) begin n_err++; $display("FAIL stall_c0: req=%0b valid=%0b pc=%h want 0/1/4", req, valid, pc); end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            n_vec++; if (req !== 1'b0 || valid !== 1'b1 || pc !== 32'h4 || instr !== mem_word(32'h4)) begin
                n_err++; $display("FAIL stall_hold%0d: req=%0b valid=%0b pc=%h instr=%h", i, req, valid, pc, instr);
            end
        end
        tick(); stall = 1'b0; #1;
        n_vec++; if (req !== 1'b0 || pc !== 32'h4) begin n_err++; $display("FAIL stall_release: req=%0b pc=%h want 0/4", req, pc); end
        tick(); #1;
        n_vec++; if (valid !== 1'b1 || pc !== 32'h8 || instr !== mem_word(32'h8) || req !== 1'b1 || addr !== 32'hC) begin
            n_err++; $display("FAIL skid_drain: valid=%0b pc=%h instr=%h req=%0b addr=%h", valid, pc, instr, req, addr);
        end
        tick(); #1;
        n_vec++; if (valid !== 1'b0 || instr !== NOP) begin n_err++; $display("FAIL post_skid_bubble: valid=%0b instr=%h", valid, instr); end
        tick(); #1;
        n_vec++; if (valid !== 1'b1 || pc !== 32'hC) begin n_err++; $display("FAIL after_skid: valid=%0b pc=%h want 1/c", valid, pc); end
    endtask

    task automatic test_redirect();
        reset_and_run(5);
        redirect = 1'b1; redirect_pc = 32'h100; #1;
        n_vec++; if (req !== 1'b1 || addr !== 32'h10) begin n_err++; $display("FAIL redir_grant: req=%0b addr=%h want 1/10", req, addr); end
        tick(); redirect = 1'b0; #1;
        n_vec++; if (valid !== 1'b0 || instr !== NOP || req !== 1'b1 || addr !== 32'h100) begin
            n_err++; $display("FAIL redir_next: valid=%0b instr=%h req=%0b addr=%h", valid, instr, req, addr);
        end
        tick(); #1;
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL redir_kill: valid=%0b pc=%h want bubble", valid, pc); end
        tick(); #1;
        n_vec++; if (valid !== 1'b1 || pc !== 32'h100 || instr !== mem_word(32'h100)) begin n_err++; $display("FAIL redir_target: valid=%0b pc=%h instr=%h", valid, pc, instr); end
    endtask

    task automatic test_redirect_stall();
        reset_and_run(4);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick(); stall = 1'b0; redirect = 1'b0; #1;
        n_vec++; if (valid !== 1'b0 || instr !== NOP || req !== 1'b1 || addr !== 32'h40) begin
            n_err++; $display("FAIL redir_stall: valid=%0b instr=%h req=%0b addr=%h", valid, instr, req, addr);
        end
        tick(); tick(); #1;
        n_vec++; if (valid !== 1'b1 || pc !== 32'h40) begin n_err++; $display("FAIL redir_stall_target: valid=%0b pc=%h want 1/40", valid, pc); end
    endtask

    task automatic test_spurious();
        reset_and_run(0);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick(); #1;
        n_vec++; if (valid !== 1'b0 || instr !== NOP) begin n_err++; $display("FAIL spurious_rvalid: valid=%0b instr=%h", valid, instr); end
    endtask

    task automatic test_wrap();
        reset_and_run(1); #1;
        n_vec++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_fetch0: req=%0b addr=%h", w_req, w_addr); end
        tick(); #1;
        n_vec++; if (w_addr !== 32'h0) begin n_err++; $display("FAIL wrap_fetch1: addr=%h want 0", w_addr); end
        tick(); #1;
        n_vec++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_instr !== mem_word(32'hFFFF_FFFC)) begin
            n_err++; $display("FAIL wrap_ifid0: valid=%0b pc=%h pc4=%h instr=%h", w_valid, w_pc, w_pc4, w_instr);
        end
        tick(); #1;
        n_vec++; if (w_valid !== 1'b1 || w_pc !== 32'h0 || w_pc4 !== 32'h4) begin n_err++; $display("FAIL wrap_ifid1: valid=%0b pc=%h pc4=%h", w_valid, w_pc, w_pc4); end
    endtask

    task automatic test_misalign();
        reset_and_run(3);
        redirect = 1'b1; redirect_pc = 32'h102;
        tick(); redirect = 1'b0; #1;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
        n_vec++; if (misalign !== 1'b1 || req !== 1'b0 || valid !== 1'b0) begin n_err++; $display("FAIL misalign_set: mis=%0b req=%0b valid=%0b", misalign, req, valid); end
        tick(); tick(); #1;
        n_vec++; if (misalign !== 1'b1 || req !== 1'b0 || valid !== 1'b0) begin n_err++; $display("FAIL misalign_sticky: mis=%0b req=%0b valid=%0b", misalign, req, valid); end
        redirect = 1'b1; redirect_pc = 32'h200;
        tick(); redirect = 1'b0; #1;
        n_vec++; if (misalign !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin n_err++; $display("FAIL misalign_clear: mis=%0b req=%0b addr=%h", misalign, req, addr); end
        tick(); tick(); #1;
        n_vec++; if (valid !== 1'b1 || pc !== 32'h200) begin n_err++; $display("FAIL misalign_resume: valid=%0b pc=%h", valid, pc); end
`else
        n_vec++; if (req !== 1'b1 || addr !== 32'h100) begin n_err++; $display("FAIL misalign_force: req=%0b addr=%h want 1/100", req, addr); end
        tick(); tick(); #1;
        n_vec++; if (valid !== 1'b1 || pc !== 32'h100) begin n_err++; $display("FAIL misalign_deliver: valid=%0b pc=%h want 1/100", valid, pc); end
`endif
    endtask

    task automatic test_random();
        reset_and_run(0);
        exp_fetch = 32'h0; exp_deliver = 32'h0;
        prev_grant = 1'b0; prev_hold = 1'b0; prev_redirect = 1'b0;
        p_valid = 1'b0; p_instr = NOP; p_pc = 32'h0; p_pc4 = 32'h4;
        delivered = 0;
        model_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 99) < 30);
            gnt         = ($urandom_range(0, 99) < 70);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        model_en = 1'b0;
        stall = 1'b0; redirect = 1'b0; gnt = 1'b1;
        n_vec++; if (delivered < 300) begin n_err++; $display("FAIL rnd_throughput: delivered %0d want >= 300", delivered); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_spurious();
        test_wrap();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
